// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one block memory between I- and D-cache
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  i_cnt,
  output logic [CNT_W-1:0]  d_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2} state_t;

  state_t            state_q;
  logic              last_d_q;    // 1 when the D side held the most recent grant
  logic              mem_read_q;
  logic              mem_write_q;
  logic              busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
  logic              req_i, req_d, grant_i, grant_d;

  // Request decode, round-robin pick and saturating counter next-state
  always_comb begin
    req_i   = i_mem_read | i_mem_write;
    req_d   = d_mem_read | d_mem_write;
    grant_i = req_i & (~req_d | last_d_q);
    grant_d = req_d & ~grant_i;
    i_cnt_d = i_cnt_q;
    d_cnt_d = d_cnt_q;
    if (state_q == GRANT_I && mem_ready && i_cnt_q != {CNT_W{1'b1}})
      i_cnt_d = i_cnt_q + CNT_W'(1);
    if (state_q == GRANT_D && mem_ready && d_cnt_q != {CNT_W{1'b1}})
      d_cnt_d = d_cnt_q + CNT_W'(1);
  end

  // Arbitration FSM: latch the winner's command, hold it until memory completes
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_cnt_q     <= '0;
      d_cnt_q     <= '0;
    end else begin
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q     <= GRANT_I;
            mem_write_q <= i_mem_write;
            mem_read_q  <= i_mem_read & ~i_mem_write;
            mem_addr_q  <= i_mem_addr;
            mem_wdata_q <= i_mem_wdata;
            busy_q      <= 1'b1;
            last_d_q    <= 1'b0;
          end else if (grant_d) begin
            state_q     <= GRANT_D;
            mem_write_q <= d_mem_write;
            mem_read_q  <= d_mem_read & ~d_mem_write;
            mem_addr_q  <= d_mem_addr;
            mem_wdata_q <= d_mem_wdata;
            busy_q      <= 1'b1;
            last_d_q    <= 1'b1;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_ready) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign i_cnt       = i_cnt_q;
  assign d_cnt       = d_cnt_q;
  // Completion is routed combinationally so the cache sees ready in the same cycle as memory
  assign i_mem_ready = (state_q == GRANT_I) & mem_ready;
  assign d_mem_ready = (state_q == GRANT_D) & mem_ready;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with random memory latency
module tb_mem_arbiter;

  localparam int CMAX = 3;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  logic         clk = 1'b0;
  logic         proc_reset = 1'b1;
  logic         i_mem_read = 1'b0, i_mem_write = 1'b0;
  logic [27:0]  i_mem_addr = '0;
  logic [127:0] i_mem_wdata = '0;
  logic [127:0] i_mem_rdata;
  logic         i_mem_ready;
  logic         d_mem_read = 1'b0, d_mem_write = 1'b0;
  logic [27:0]  d_mem_addr = '0;
  logic [127:0] d_mem_wdata = '0;
  logic [127:0] d_mem_rdata;
  logic         d_mem_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic         busy;
  logic [1:0]   i_cnt, d_cnt;

  int total = 0;
  int bad = 0;

  txn_t exp_q0[$];
  txn_t exp_q1[$];

  int           lat_min = 1, lat_max = 4;
  bit           fixed_en = 1'b0;
  logic [127:0] fixed_rdata = 128'hDEADBEEF_00000000_00000000_00000001;

  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .CNT_W(2)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .i_cnt(i_cnt), .d_cnt(d_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Memory: accepts a held command, pulses ready after a random latency
  initial begin
    int mcnt;
    mcnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = fixed_en ? fixed_rdata : {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (mem_read || mem_write) begin
        mcnt = $urandom_range(lat_max, lat_min);
      end
    end
  end

  // Reference model and monitor: one outstanding transaction, alternate on ties
  initial begin
    bit   m_valid, m_busy, m_owner, m_last, r0, r1, w;
    int   m_icnt, m_dcnt;
    txn_t m_cur;
    m_valid = 0; m_busy = 0; m_owner = 0; m_last = 1; m_icnt = 0; m_dcnt = 0;
    m_cur.wr = 0; m_cur.addr = '0; m_cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("busy", busy, m_busy);
        chk("mem_read", mem_read, m_busy && !m_cur.wr);
        chk("mem_write", mem_write, m_busy && m_cur.wr);
        if (m_busy) begin
          chk("mem_addr", mem_addr, m_cur.addr);
          chk("mem_wdata", mem_wdata, m_cur.wdata);
        end
        chk("i_cnt", i_cnt, m_icnt);
        chk("d_cnt", d_cnt, m_dcnt);
        chk("i_mem_ready", i_mem_ready, m_busy && !m_owner && mem_ready);
        chk("d_mem_ready", d_mem_ready, m_busy && m_owner && mem_ready);
        if (i_mem_ready) chk("i_mem_rdata", i_mem_rdata, mem_rdata);
        if (d_mem_ready) chk("d_mem_rdata", d_mem_rdata, mem_rdata);
      end
      if (proc_reset) begin
        m_valid = 1; m_busy = 0; m_last = 1; m_icnt = 0; m_dcnt = 0;
        exp_q0.delete();
        exp_q1.delete();
      end else if (m_valid && m_busy) begin
        if (mem_ready) begin
          m_busy = 0;
          if (!m_owner) m_icnt = (m_icnt < CMAX) ? m_icnt + 1 : CMAX;
          else          m_dcnt = (m_dcnt < CMAX) ? m_dcnt + 1 : CMAX;
        end
      end else if (m_valid) begin
        r0 = i_mem_read | i_mem_write;
        r1 = d_mem_read | d_mem_write;
        if (r0 || r1) begin
          w = (r0 && r1) ? !m_last : r1;
          total++;
          if ((w ? exp_q1.size() : exp_q0.size()) == 0) begin
            bad++;
            $display("FAIL grant: client %0d requesting with no expected transaction", w);
          end else begin
            m_cur   = w ? exp_q1.pop_front() : exp_q0.pop_front();
            m_busy  = 1;
            m_owner = w;
            m_last  = w;
          end
        end
      end
    end
  end

  task automatic drive(input bit c, input bit rd, input bit wr,
                       input logic [27:0] a, input logic [127:0] wd);
    if (!c) begin
      i_mem_read = rd; i_mem_write = wr; i_mem_addr = a; i_mem_wdata = wd;
    end else begin
      d_mem_read = rd; d_mem_write = wr; d_mem_addr = a; d_mem_wdata = wd;
    end
  endtask

  task automatic client_idle(input bit c);
    @(posedge clk); #1;
    drive(c, 1'b0, 1'b0, '0, '0);
  endtask

  // Raise a request, record what memory must see, wait for this client's ready
  task automatic req(input bit c, input bit rd, input bit wr, input logic [27:0] a,
                     input logic [127:0] wd, input bit drop);
    txn_t t;
    bit   got;
    @(posedge clk); #1;
    drive(c, rd, wr, a, wd);
    t.wr = wr; t.addr = a; t.wdata = wd;
    if (!c) exp_q0.push_back(t); else exp_q1.push_back(t);
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (!c ? i_mem_ready : d_mem_ready) got = 1;
      else if (drop && k == 2) begin
        @(posedge clk); #1;
        drive(c, 1'b0, 1'b0, a ^ 28'h0000FFF, ~wd);
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ready_timeout: client %0d addr %h got no ready, expected one", c, a);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 proc_reset = 1'b1;
    @(posedge clk); #1 proc_reset = 1'b0;
    @(negedge clk);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
  endtask

  task automatic rand_client(input bit c, input int n);
    int           op, gap;
    logic [127:0] wd;
    for (int j = 0; j < n; j++) begin
      op = $urandom_range(2, 0);
      wd = {$urandom, $urandom, $urandom, $urandom};
      req(c, op != 1, op != 0, 28'($urandom), wd, 1'b0);
      gap = $urandom_range(2, 0);
      if (gap > 0) begin
        client_idle(c);
        repeat (gap - 1) @(posedge clk);
      end
    end
    client_idle(c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;
    @(negedge clk);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_busy", busy, 0);

    // single I read, memory answers four cycles after seeing the command
    fixed_en = 1'b1; lat_min = 4; lat_max = 4;
    req(1'b0, 1'b1, 1'b0, 28'h0000010, '0, 1'b0);
    chk("single_rdata", i_mem_rdata, 128'hDEADBEEF_00000000_00000000_00000001);
    client_idle(1'b0);
    fixed_en = 1'b0;
    @(negedge clk);
    chk("single_i_cnt", i_cnt, 1);

    // simultaneous then continuous requests from both sides
    do_reset();
    lat_min = 1; lat_max = 4;
    fork
      begin
        req(1'b0, 1'b1, 1'b0, 28'h0000010, '0, 1'b0);
        req(1'b0, 1'b1, 1'b0, 28'h0000014, '0, 1'b0);
        client_idle(1'b0);
      end
      begin
        req(1'b1, 1'b0, 1'b1, 28'h0000020, {16{8'h5A}}, 1'b0);
        req(1'b1, 1'b0, 1'b1, 28'h0000024, {16{8'hA5}}, 1'b0);
        client_idle(1'b1);
      end
    join
    @(negedge clk);
    chk("alt_i_cnt", i_cnt, 2);
    chk("alt_d_cnt", d_cnt, 2);

    // D write whose inputs change and drop while it is outstanding
    lat_min = 5; lat_max = 5;
    req(1'b1, 1'b0, 1'b1, 28'h0000040, {8{16'hC3C3}}, 1'b1);
    client_idle(1'b1);

    // read and write together on D is a write
    lat_min = 1; lat_max = 3;
    req(1'b1, 1'b1, 1'b1, 28'h0000030, {4{32'h12345678}}, 1'b0);
    client_idle(1'b1);

    // reset while I is granted; the late memory ready must be ignored
    lat_min = 6; lat_max = 6;
    begin
      txn_t t;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 28'h0000050, 128'h77);
      t.wr = 1'b0; t.addr = 28'h0000050; t.wdata = 128'h77;
      exp_q0.push_back(t);
      repeat (3) @(posedge clk);
      #1 proc_reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1 proc_reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_mem_read", mem_read, 0);
      chk("abort_i_cnt", i_cnt, 0);
      repeat (10) @(posedge clk);
    end

    // five D transactions on a 2-bit counter
    do_reset();
    lat_min = 1; lat_max = 3;
    repeat (5) req(1'b1, 1'b0, 1'b1, 28'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    client_idle(1'b1);
    @(negedge clk);
    chk("sat_d_cnt", d_cnt, 3);

    // random traffic from both clients
    do_reset();
    lat_min = 1; lat_max = 4;
    fork
      rand_client(1'b0, 40);
      rand_client(1'b1, 40);
    join
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
